// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and alignment helpers for the CCM load/store unit.
// The misalignment check is built only with LSU_MISALIGN_CHECK_EN defined.
package lsu_pkg;

    localparam logic [1:0] SIZE_SB = 2'b01;
    localparam logic [1:0] SIZE_SH = 2'b10;
    localparam logic [1:0] SIZE_SW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // The illegal size code 00 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b00) ? SIZE_SW : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SIZE_SH) && offset[0]) ||
               ((size == SIZE_SW) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_ccm_master_if.sv
// Core request/response channel plus closely-coupled memory port of the LSU.
// master = the LSU itself, slave = the core and memory it talks to.
interface lsu_ccm_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_adr;
    logic [31:0] mem_d;
    logic [1:0]  mem_store_type;
    logic [1:0]  mem_store_offset;
    logic        mem_we;
    logic [31:0] mem_q;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  resp_ready, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_adr, mem_d, mem_store_type, mem_store_offset, mem_we
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output resp_ready, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_adr, mem_d, mem_store_type, mem_store_offset, mem_we
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load data alignment: picks the byte/half lane out of the memory
// word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_q_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        ext_bit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_q_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lane[offset_i];
        half_sel = offset_i[1] ? mem_q_i[31:16] : mem_q_i[15:0];
        ext_bit  = 1'b0;
        data_o   = mem_q_i;
        case (size_i)
            SIZE_SB: begin
                ext_bit = ~unsigned_i & byte_sel[7];
                data_o  = {{24{ext_bit}}, byte_sel};
            end
            SIZE_SH: begin
                ext_bit = ~unsigned_i & half_sel[15];
                data_o  = {{16{ext_bit}}, half_sel};
            end
            default: data_o = mem_q_i;
        endcase
    end

endmodule

// File: rtl/lsu_ccm_master.sv
// Load/store unit driving a closely-coupled memory: IDLE -> ISSUE -> (WAIT) -> RESP.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses with resp_err.
module lsu_ccm_master
    import lsu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    lsu_ccm_master_if.master   bus
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_data;
    logic        req_mis;

    lsu_load_align u_load_align (
        .mem_q_i    (bus.mem_q),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_data)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q, err_d;

    assign req_mis = is_misaligned(norm_size(bus.req_size), bus.req_addr[1:0]);

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && bus.req_valid) begin
            err_d = req_mis;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.resp_err = err_q;
`else
    assign req_mis      = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // A rejected access leaves the request registers (and so the memory port) untouched.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    rdata_d = '0;
                    if (req_mis) begin
                        state_d = ST_RESP;
                    end else begin
                        we_d    = bus.req_we;
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                        size_d  = norm_size(bus.req_size);
                        uns_d   = bus.req_unsigned;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = we_q ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
        end
    end

    // Write strobe is decoded from state so an asynchronous reset kills it at once.
    assign bus.mem_we           = (state_q == ST_ISSUE) && we_q;
    assign bus.mem_adr          = {2'b00, addr_q[31:2]};
    assign bus.mem_d            = wdata_q;
    assign bus.mem_store_type   = size_q;
    assign bus.mem_store_offset = addr_q[1:0];
    assign bus.req_ready        = (state_q == ST_IDLE);
    assign bus.resp_valid       = (state_q == ST_RESP);
    assign bus.resp_rdata       = rdata_q;

endmodule

// File: tb/tb_lsu_ccm_master.sv
// Self-checking bench for lsu_ccm_master: directed cases followed by random accesses,
// all checked against a byte-addressed reference memory model.
module tb_lsu_ccm_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_ccm_master_if bus ();

    lsu_ccm_master dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Word-organised memory slave with lane writes and a one-cycle registered read.
    logic [31:0] sram [16] = '{default: 32'h0};

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            case (bus.mem_store_type)
                2'b01: sram[bus.mem_adr[3:0]][8*bus.mem_store_offset +: 8] <= bus.mem_d[7:0];
                2'b10: begin
                    if (bus.mem_store_offset[1]) sram[bus.mem_adr[3:0]][31:16] <= bus.mem_d[15:0];
                    else                         sram[bus.mem_adr[3:0]][15:0]  <= bus.mem_d[15:0];
                end
                default: sram[bus.mem_adr[3:0]] <= bus.mem_d;
            endcase
        end
        bus.mem_q <= sram[bus.mem_adr[3:0]];
    end

    int          we_total = 0;
    logic [31:0] we_adr   = '0;
    logic [1:0]  we_type  = '0;
    logic [1:0]  we_off   = '0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_total <= we_total + 1;
            we_adr   <= bus.mem_adr;
            we_type  <= bus.mem_store_type;
            we_off   <= bus.mem_store_offset;
        end
    end

    // Reference model: 64-byte little-endian memory, byte addresses taken modulo 64.
    logic [7:0] ref_mem [64] = '{default: 8'h0};

    function automatic int ref_nbytes(input logic [1:0] size);
        return (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
    endfunction

    function automatic int ref_base(input logic [31:0] addr, input logic [1:0] size);
        int n = ref_nbytes(size);
        int a = int'(addr % 64);
        return (a / n) * n;
    endfunction

    function automatic logic ref_mis(input logic [31:0] addr, input logic [1:0] size);
`ifdef LSU_MISALIGN_CHECK_EN
        return (addr % ref_nbytes(size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int n    = ref_nbytes(size);
        int base = ref_base(addr, size);
        logic [31:0] val = '0;
        for (int k = 0; k < n; k++) val = val + ({24'h0, ref_mem[base + k]} << (8 * k));
        if (n < 4 && !uns && val[8*n-1]) val = val - (32'd1 << (8 * n));
        return val;
    endfunction

    function automatic void ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n    = ref_nbytes(size);
        int base = ref_base(addr, size);
        for (int k = 0; k < n; k++) ref_mem[base + k] = wdata[8*k +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                             input int hold, input logic use_want, input logic [31:0] want);
        logic        mis      = ref_mis(addr, size);
        logic [31:0] exp_data = (we || mis) ? 32'h0 : ref_load(addr, size, uns);
        int          exp_lat  = mis ? 1 : (we ? 2 : 3);
        int          exp_we   = (we && !mis) ? 1 : 0;
        int          lat;
        int          we0;
        logic [31:0] adr0;
        logic [31:0] got;
        logic        got_err;

        @(negedge clk);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        adr0             = bus.mem_adr;
        we0              = we_total;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        got     = bus.resp_rdata;
        got_err = bus.resp_err;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rdata"}, got, exp_data);
        chk({tag, "_err"}, got_err, mis);
        if (use_want) chk({tag, "_rdata_const"}, got, want);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, bus.resp_valid, 1);
            chk({tag, "_hold_rdata"}, bus.resp_rdata, exp_data);
            chk({tag, "_hold_ready"}, bus.req_ready, 0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        chk({tag, "_after_valid"}, bus.resp_valid, 0);
        chk({tag, "_after_ready"}, bus.req_ready, 1);
        chk({tag, "_we_cycles"}, we_total - we0, exp_we);
        if (exp_we == 1) begin
            chk({tag, "_mem_adr"}, we_adr, {2'b00, addr[31:2]});
            chk({tag, "_store_type"}, we_type, (size == 2'b00) ? 2'b11 : size);
            chk({tag, "_store_off"}, we_off, addr[1:0]);
        end
        if (mis) chk({tag, "_adr_kept"}, bus.mem_adr, adr0);
        if (we && !mis) ref_store(addr, size, wdata);
        $display("[TB] %s we=%0d addr=%h size=%0d uns=%0d rdata=%h err=%0d lat=%0d hold=%0d",
                 tag, we, addr, size, uns, got, got_err, lat, hold);
    endtask

    initial begin
        logic [31:0] r_addr;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_size     = '0;
        bus.req_unsigned = 1'b0;
        bus.resp_ready   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_adr", bus.mem_adr, 0);
        rst_n = 1'b1;

        do_access("sw_4", 1'b1, 32'h4, 32'hDEADBEEF, 2'b11, 1'b0, 0, 1'b0, 32'h0);
        chk("sw_4_mem_adr_const", we_adr, 32'h1);
        do_access("lb_7",  1'b0, 32'h7, 32'h0, 2'b01, 1'b0, 0, 1'b1, 32'hFFFFFFDE);
        do_access("lbu_7", 1'b0, 32'h7, 32'h0, 2'b01, 1'b1, 0, 1'b1, 32'h000000DE);
        do_access("lh_6",  1'b0, 32'h6, 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'hFFFFDEAD);
        do_access("lhu_4", 1'b0, 32'h4, 32'h0, 2'b10, 1'b1, 5, 1'b1, 32'h0000BEEF);
        do_access("sb_5",  1'b1, 32'h5, 32'h12, 2'b01, 1'b0, 0, 1'b0, 32'h0);
        chk("sb_5_off_const", we_off, 2'b01);
        do_access("lw_4",  1'b0, 32'h4, 32'h0, 2'b11, 1'b0, 0, 1'b1, 32'hDEAD12EF);
`ifdef LSU_MISALIGN_CHECK_EN
        do_access("lw_6_mis", 1'b0, 32'h6, 32'h0, 2'b11, 1'b0, 0, 1'b1, 32'h0);
        do_access("sw_2_mis", 1'b1, 32'h2, 32'h55AA55AA, 2'b11, 1'b0, 0, 1'b0, 32'h0);
`else
        do_access("lw_6_nochk", 1'b0, 32'h6, 32'h0, 2'b11, 1'b0, 0, 1'b1, 32'hDEAD12EF);
`endif

        // Reset while a store sits in ISSUE: the strobe must drop without waiting for a clock.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h8;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_size  = 2'b11;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("rstmid_we_before", bus.mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_we_now", bus.mem_we, 0);
        chk("rstmid_resp_valid", bus.resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_req_ready", bus.req_ready, 1);
        chk("rstmid_resp_valid_after", bus.resp_valid, 0);
        $display("[TB] reset_mid_store addr=00000008 we=%0d ready=%0d", bus.mem_we, bus.req_ready);
        do_access("lw_8_after_rst", 1'b0, 32'h8, 32'h0, 2'b11, 1'b0, 0, 1'b1, 32'h0);

        for (int i = 0; i < 60; i++) begin
            r_addr = $urandom();
            do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), r_addr, $urandom(),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_ccm_master.md
LSU_CCM_MASTER -- requirements
Module: lsu_ccm_master

Interface
REQ-001 CLK  input  1  single clock; all state updates on its rising edge.
REQ-002 RST_N  input  1  reset, asynchronous and active-low.
REQ-003 req_valid  input  1  core request valid.
REQ-004 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 req_size  input  2  01 = byte, 10 = half, 11 = word; 00 is illegal and is treated as word.
REQ-009 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 resp_valid  output  1  response valid.
REQ-011 resp_ready  input  1  core accepts the response.
REQ-012 resp_rdata  output  32  load result; 0 for stores.
REQ-013 resp_err  output  1  misaligned access.
REQ-014 mem_adr  output  32  word index, {2'b00, addr[31:2]}.
REQ-015 mem_d  output  32  req_wdata unchanged; the memory selects byte lanes.
REQ-016 mem_store_type  output  2  req_size (SB = 01, SH = 10, SW = 11).
REQ-017 mem_store_offset  output  2  addr[1:0].
REQ-018 mem_we  output  1  write enable, high for exactly one cycle per store.
REQ-019 mem_q  input  32  read word, valid the cycle after the read cycle.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE: when req_valid is high, the block SHALL register the request and move to ISSUE, or to RESP with resp_err = 1 if the access is misaligned (macro on).
REQ-022 ISSUE SHALL drive mem_* from the registered request for one cycle; a load then moves to WAIT, a store moves to RESP.
REQ-023 mem_we SHALL be decoded combinationally as (state == ISSUE && we) and SHALL be 0 in every other state.
REQ-024 WAIT SHALL register mem_q after byte/half extraction and extension, then move to RESP.
REQ-025 Byte extraction SHALL select mem_q[8*off+7 : 8*off]; half extraction SHALL select mem_q[31:16] if addr[1] = 1, else mem_q[15:0].
REQ-026 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready is high, then return to IDLE.
REQ-027 No new request SHALL be accepted in the cycle of the response handshake.
REQ-028 Latency from the accepting edge to resp_valid SHALL be: load 3 cycles, store 2 cycles, misaligned 1 cycle.
REQ-029 A misaligned access SHALL NOT assert mem_we and SHALL NOT change mem_adr.
REQ-030 mem_adr, mem_d, mem_store_type and mem_store_offset SHALL stay stable from ISSUE through WAIT.

Reset
REQ-031 On RST_N low (asynchronous) the block SHALL enter IDLE with all registers at 0: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_adr = 0.
REQ-032 Reset asserted during ISSUE or WAIT SHALL abort the access and force mem_we low immediately, with no response.

Configuration
REQ-033 Macro LSU_MISALIGN_CHECK_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, SHALL produce resp_err = 1 and no memory access.
REQ-034 Macro LSU_MISALIGN_CHECK_EN not defined: no misalignment check; resp_err SHALL be tied to 0 and low address bits are ignored per the extraction rules (a word access uses the full word).

Structure
REQ-035 Package lsu_pkg SHALL hold the SB/SH/SW size constants (01/10/11) and the FSM state enum.
REQ-036 Sub-module lsu_load_align SHALL be combinational and perform extraction plus sign/zero extension: inputs mem_q, offset, size, unsigned; output 32-bit data.

Verification
REQ-037 Store word: SW addr 0x4, data 0xDEADBEEF -> mem_adr = 1, mem_store_type = 11, mem_we high for exactly 1 cycle, resp_valid 2 cycles after accept.
REQ-038 Byte and half loads on word 0xDEADBEEF at 0x4:
- LB 0x7 -> 0xFFFFFFDE
- LBU 0x7 -> 0x000000DE
- LH 0x6 -> 0xFFFFDEAD
- LHU 0x4 -> 0x0000BEEF
Each response arrives 3 cycles after accept.
REQ-039 Store byte then load word: SB addr 0x5, data 0x12 -> mem_store_offset = 01; then LW 0x4 -> 0xDEAD12EF.
REQ-040 Misaligned LW 0x6: with the macro -> resp_err = 1 after 1 cycle, mem_we never high; without the macro -> resp_rdata = word 1, resp_err = 0.
REQ-041 Backpressure: resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable, req_ready = 0; handshake on cycle 6 -> IDLE the next cycle.
REQ-042 Reset mid-store: RST_N low during ISSUE -> mem_we = 0 in the same cycle, resp_valid = 0, req_ready = 1 once RST_N is released.
